// File: rtl/ex_alu_stage.sv
// Execute-stage ALU with a single output register and a valid/ready handshake.
// The ALU result, zero flag, signed-overflow flag and the pass-through
// destination tag are captured together. The stage holds them until the
// memory/writeback stage takes them. A retired-op counter tracks completed transfers.
//
// Handshake: a transfer happens on any rising edge where valid and ready are both 1.
// The producer must hold valid and its payload stable until that edge. The
// upstream ready (in_ready) is combinational from out_ready, so a full stage whose
// result is being taken can accept a new op in the same cycle (1 op/cycle).

module ex_alu_stage #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4:0]           ALUCtrl,
    input  logic                 Sign,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic [4:0]           in_rd,
    input  logic                 in_reg_write,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_result,
    output logic                 out_zero,
    output logic                 out_ovf,
    output logic [4:0]           out_rd,
    output logic                 out_reg_write,
    output logic [CNT_WIDTH-1:0] op_count,
    output logic                 stage_state
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_OR  = 5'b00001;
    localparam logic [4:0] OP_AND = 5'b00010;
    localparam logic [4:0] OP_SUB = 5'b00110;
    localparam logic [4:0] OP_SLT = 5'b00111;
    localparam logic [4:0] OP_NOR = 5'b01100;
    localparam logic [4:0] OP_XOR = 5'b01101;
    localparam logic [4:0] OP_SRL = 5'b10000;
    localparam logic [4:0] OP_SRA = 5'b11000;
    localparam logic [4:0] OP_SLL = 5'b11001;

    state_t           state;
    logic             accept;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [4:0]       shamt;
    logic             slt;
    logic [WIDTH-1:0] alu_result;
    logic             alu_ovf;

    assign out_valid   = (state == FULL);
    assign stage_state = state;
    assign in_ready    = !out_valid || out_ready;
    assign accept      = in_valid && in_ready;

    assign sum   = in_a + in_b;
    assign diff  = in_a - in_b;
    assign shamt = in_a[4:0];
    assign slt   = Sign ? ($signed(in_a) < $signed(in_b)) : (in_a < in_b);

    // Combinational ALU: result and signed-overflow flag for the offered operation
    always_comb begin
        alu_result = '0;
        alu_ovf    = 1'b0;
        case (ALUCtrl)
            OP_ADD: begin
                alu_result = sum;
                alu_ovf    = Sign && (in_a[WIDTH-1] == in_b[WIDTH-1])
                                  && (sum[WIDTH-1] != in_a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_result = diff;
                alu_ovf    = Sign && (in_a[WIDTH-1] != in_b[WIDTH-1])
                                  && (diff[WIDTH-1] != in_a[WIDTH-1]);
            end
            OP_OR:   alu_result = in_a | in_b;
            OP_AND:  alu_result = in_a & in_b;
            OP_NOR:  alu_result = ~(in_a | in_b);
            OP_XOR:  alu_result = in_a ^ in_b;
            OP_SLT:  alu_result = {{(WIDTH-1){1'b0}}, slt};
            OP_SRL:  alu_result = in_b >> shamt;
            OP_SRA:  alu_result = $unsigned($signed(in_b) >>> shamt);
            OP_SLL:  alu_result = in_b << shamt;
            default: begin
                alu_result = '0;
                alu_ovf    = 1'b0;
            end
        endcase
    end

    // Stage FSM, output register and retired-op counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= EMPTY;
            out_result    <= '0;
            out_zero      <= 1'b0;
            out_ovf       <= 1'b0;
            out_rd        <= '0;
            out_reg_write <= 1'b0;
            op_count      <= '0;
        end else begin
            // A result taken downstream counts even if a flush lands in the same cycle
            if (out_valid && out_ready) begin
                op_count <= op_count + CNT_WIDTH'(1);
            end
            if (flush) begin
                // Redirect: drop the held result and anything accepted this cycle
                state <= EMPTY;
            end else if (accept) begin
                state         <= FULL;
                out_result    <= alu_result;
                out_zero      <= (alu_result == '0);
                out_ovf       <= alu_ovf;
                out_rd        <= in_rd;
                out_reg_write <= in_reg_write;
            end else if (out_ready) begin
                // Result drained and nothing new offered
                state <= EMPTY;
            end
        end
    end

endmodule
